// File: rtl/adxl362_fifo_reader_if.sv
// adxl362_fifo_reader_if
//   Bundles the request/status handshake, the SPI pins and the sample
//   stream of adxl362_fifo_reader so that they travel as one port.
//
//   Request : start, num_words              (requester -> reader)
//   Status  : busy, done                    (reader -> requester)
//   SPI     : sclk, cs_n, mosi (out), miso (in)
//   Stream  : sample_data, sample_axis, sample_valid (out), sample_ready (in)
//
//   slave  modport : the reader itself
//   master modport : the environment (requester, SPI device, consumer)
interface adxl362_fifo_reader_if;
   logic        start;
   logic [9:0]  num_words;
   logic        busy;
   logic        done;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic [13:0] sample_data;
   logic [1:0]  sample_axis;
   logic        sample_valid;
   logic        sample_ready;

   modport slave (
      input  start, num_words, miso, sample_ready,
      output busy, done, sclk, cs_n, mosi, sample_data, sample_axis, sample_valid
   );

   modport master (
      output start, num_words, miso, sample_ready,
      input  busy, done, sclk, cs_n, mosi, sample_data, sample_axis, sample_valid
   );
endinterface

// File: rtl/adxl362_fifo_reader.sv
// adxl362_fifo_reader
//   Drains num_words entries from the ADXL362 FIFO over SPI mode 0.
//   A transaction is: cs_n low, one idle half-period, the FIFO-read
//   command byte 0x0D, then 16 bits per entry (low byte first, each byte
//   MSB first), one idle half-period, cs_n high. Each entry is presented
//   on a valid/ready output register; SCLK is parked low between entries
//   while the previous entry is still waiting for the consumer.
//
//   Parameters: CLK_DIV   SCLK half-period in clk cycles (2..255)
//               MAX_WORDS largest num_words accepted
//   Ports     : clk  system clock
//               rst  asynchronous active-low reset
//               bus  adxl362_fifo_reader_if.slave (request, status, SPI, stream)
module adxl362_fifo_reader #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned MAX_WORDS = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   adxl362_fifo_reader_if.slave bus
);

   localparam logic [7:0] CMD_BYTE = 8'h0D;
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, CMD, WORD, STALL, HOLD, FINISH
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;          // cycle count within a half-period
   logic [3:0]  bit_q, bit_d;          // bit index within the byte / entry
   logic [15:0] shift_q, shift_d;      // received bits, first byte in the top
   logic [9:0]  word_cnt_q, word_cnt_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        cs_n_q, cs_n_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        valid_q, valid_d;
   logic [13:0] data_q, data_d;
   logic [1:0]  axis_q, axis_d;

   logic       half_end, rise, fall, count_ok, active_d;
   logic [3:0] bit_nxt;

   assign half_end = (div_q == DIV_LAST);
   assign rise     = half_end & ~sclk_q;   // this edge raises SCLK and samples miso
   assign fall     = half_end &  sclk_q;   // this edge ends the current bit
   assign bit_nxt  = bit_q + 4'd1;
   assign count_ok = (bus.num_words != 10'd0) && (32'(bus.num_words) <= MAX_WORDS);

   // NOTE: every variable assigned here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      word_cnt_d = word_cnt_q;
      sclk_d     = 1'b0;
      mosi_d     = 1'b0;
      valid_d    = valid_q;
      data_d     = data_q;
      axis_d     = axis_q;

      if (valid_q && bus.sample_ready) begin
         valid_d = 1'b0;
      end

      // Shared bit timing: CLK_DIV cycles low, then CLK_DIV cycles high.
      if (state_q == CMD || state_q == WORD) begin
         sclk_d = half_end ? ~sclk_q : sclk_q;
         div_d  = half_end ? 8'd0 : div_q + 8'd1;
      end

      unique case (state_q)
         IDLE: begin
            // An unconsumed entry blocks new requests entirely.
            if (bus.start && !valid_q) begin
               if (count_ok) begin
                  state_d    = SETUP;
                  div_d      = 8'd0;
                  word_cnt_d = bus.num_words;
               end else begin
                  state_d = FINISH;   // reject: done pulse only, no SPI activity
               end
            end
         end
         SETUP: begin
            div_d = div_q + 8'd1;
            if (half_end) begin
               state_d = CMD;
               div_d   = 8'd0;
               bit_d   = 4'd0;
               mosi_d  = CMD_BYTE[7];
            end
         end
         CMD: begin
            mosi_d = mosi_q;
            if (fall) begin
               if (bit_q == 4'd7) begin
                  state_d = WORD;
                  bit_d   = 4'd0;
                  mosi_d  = 1'b0;
               end else begin
                  bit_d  = bit_nxt;
                  mosi_d = CMD_BYTE[~bit_nxt[2:0]];
               end
            end
         end
         WORD: begin
            if (rise) begin
               shift_d = {shift_q[14:0], bus.miso};
            end
            // First cycle after the 16th sample: publish {high byte, low byte}.
            if (bit_q == 4'd15 && sclk_q && div_q == 8'd0) begin
               valid_d    = 1'b1;
               axis_d     = shift_q[7:6];
               data_d     = {shift_q[5:0], shift_q[15:8]};
               word_cnt_d = word_cnt_q - 10'd1;
            end
            if (fall) begin
               bit_d = bit_nxt;
               if (bit_q == 4'd15) begin
                  if (word_cnt_q == 10'd0) begin
                     state_d = HOLD;
                  end else if (valid_q && !bus.sample_ready) begin
                     state_d = STALL;
                  end
               end
            end
         end
         STALL: begin
            div_d = 8'd0;
            if (!valid_q || bus.sample_ready) begin
               state_d = WORD;
            end
         end
         HOLD: begin
            div_d = div_q + 8'd1;
            if (half_end) begin
               state_d = FINISH;
               div_d   = 8'd0;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status pins are registered decodes of the next state.
      active_d = state_d inside {SETUP, CMD, WORD, STALL, HOLD};
      cs_n_d   = ~active_d;
      busy_d   = active_d;
      done_d   = (state_d == FINISH);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the sample data/axis registers are reset as well, because
         // their values are visible on the ports straight out of reset.
         state_q    <= IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         word_cnt_q <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         axis_q     <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         word_cnt_q <= word_cnt_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         axis_q     <= axis_d;
      end
   end

   assign bus.sclk         = sclk_q;
   assign bus.mosi         = mosi_q;
   assign bus.cs_n         = cs_n_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.sample_valid = valid_q;
   assign bus.sample_data  = data_q;
   assign bus.sample_axis  = axis_q;

endmodule

// File: tb/tb_adxl362_fifo_reader.sv
// tb_adxl362_fifo_reader
//   Directed and randomized transactions against a behavioural model of
//   the ADXL362 FIFO: the device side serves entries as a bit stream (one
//   command byte of don't-care, then low byte / high byte of each entry,
//   MSB first); the consumer side collects accepted entries and compares
//   them, plus SCLK edge counts, the command byte and done pulses.
module tb_adxl362_fifo_reader;

   localparam int CLK_DIV   = 4;
   localparam int MAX_WORDS = 512;

   logic clk;
   logic rst;
   bit   clk_en = 1'b0;

   adxl362_fifo_reader_if bus();

   adxl362_fifo_reader #(.CLK_DIV(CLK_DIV), .MAX_WORDS(MAX_WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   logic [15:0] tx_q[$];      // entries the device will return
   logic [15:0] got_q[$];     // entries the consumer accepted
   int          rises, mosi_bad, done_cnt, done_busy_bad, stall_bad, hold_bad;
   logic [7:0]  mosi_cmd;
   bit          cs_low_seen, stalling, rand_ready, hold_seen;
   logic [15:0] hold_val;

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit k of the device stream (k = number of SCLK rises so far).
   function automatic logic miso_bit(input int k);
      int j, b;
      logic [15:0] e;
      if (k < 8) return 1'b0;
      j = (k - 8) / 16;
      b = (k - 8) % 16;
      if (j >= tx_q.size()) return 1'b0;
      e = tx_q[j];
      return (b < 8) ? e[7 - b] : e[23 - b];
   endfunction

   // Device: presents the next bit while SCLK is low.
   always @(negedge bus.cs_n or negedge bus.sclk) bus.miso = miso_bit(rises);

   // SCLK rise monitor: collects the command byte and counts edges.
   always @(posedge bus.sclk) begin
      if (rises < 8) mosi_cmd = {mosi_cmd[6:0], bus.mosi};
      else if (bus.mosi !== 1'b0) mosi_bad++;
      rises++;
   end

   // Consumer / status monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         done_cnt++;
         if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) done_busy_bad++;
      end
      if (bus.cs_n === 1'b0) cs_low_seen = 1'b1;
      if (stalling && (bus.sclk !== 1'b0 || bus.cs_n !== 1'b0)) stall_bad++;
      if (bus.sample_valid === 1'b1) begin
         if (hold_seen && {bus.sample_axis, bus.sample_data} !== hold_val) hold_bad++;
         hold_seen = !bus.sample_ready;
         hold_val  = {bus.sample_axis, bus.sample_data};
         if (bus.sample_ready) got_q.push_back({bus.sample_axis, bus.sample_data});
      end else begin
         hold_seen = 1'b0;
      end
   end

   // Randomly throttled consumer.
   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         bus.sample_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic clear_mon();
      rises = 0; mosi_bad = 0; done_cnt = 0; done_busy_bad = 0;
      stall_bad = 0; hold_bad = 0; mosi_cmd = 8'h00;
      cs_low_seen = 1'b0; hold_seen = 1'b0;
      got_q.delete();
   endtask

   task automatic pulse_start(input logic [9:0] n);
      @(posedge clk); #1;
      bus.num_words = n;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (done_cnt == 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("done_seen", 32'(done_cnt != 0), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_samples(input int n, input int budget);
      int c = 0;
      while (got_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic check_txn(input int n);
      check("sclk_rises", 32'(rises), 32'(8 + 16 * n));
      check("mosi_cmd", 32'(mosi_cmd), 32'h0D);
      check("mosi_idle", 32'(mosi_bad), 32'd0);
      check("done_count", 32'(done_cnt), 32'd1);
      check("done_status", 32'(done_busy_bad), 32'd0);
      check("n_samples", 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n && i < got_q.size(); i++)
         check($sformatf("sample%0d", i), 32'(got_q[i]), 32'(tx_q[i]));
   endtask

   task automatic reject_case(input logic [9:0] n);
      clear_mon();
      pulse_start(n);
      check("rej_done", 32'(bus.done), 32'd1);
      check("rej_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      check("rej_done_pulse", 32'(bus.done), 32'd0);
      repeat (20) @(negedge clk);
      check("rej_cs", 32'(cs_low_seen), 32'd0);
      check("rej_done_cnt", 32'(done_cnt), 32'd1);
      check("rej_rises", 32'(rises), 32'd0);
   endtask

   initial begin
      int c, n, snap;

      // Reset with the clock stopped: outputs must settle immediately.
      rst = 1'b1;
      bus.start = 1'b0; bus.num_words = '0; bus.miso = 1'b0; bus.sample_ready = 1'b1;
      clear_mon();
      #1 rst = 1'b0;
      #1;
      check("rst_cs_n", 32'(bus.cs_n), 32'd1);
      check("rst_sclk", 32'(bus.sclk), 32'd0);
      check("rst_mosi", 32'(bus.mosi), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_valid", 32'(bus.sample_valid), 32'd0);
      check("rst_data", 32'(bus.sample_data), 32'd0);
      check("rst_axis", 32'(bus.sample_axis), 32'd0);
      #8 rst = 1'b1;
      clk_en = 1'b1;
      repeat (3) @(negedge clk);

      // Single entry: bytes 0x34 then 0x81.
      tx_q = '{16'h8134};
      clear_mon();
      pulse_start(10'd1);
      check("A_busy", 32'(bus.busy), 32'd1);
      check("A_cs_n", 32'(bus.cs_n), 32'd0);
      wait_done(1000);
      check_txn(1);
      check("A_axis", 32'(got_q.size() > 0 ? got_q[0][15:14] : 2'bxx), 32'd2);
      check("A_data", 32'(got_q.size() > 0 ? got_q[0][13:0] : 14'bx), 32'h0134);

      // Three entries, one per axis.
      tx_q = '{16'h0001, 16'h4002, 16'h8003};
      clear_mon();
      pulse_start(10'd3);
      wait_done(2000);
      check_txn(3);

      // Consumer stall of 100 cycles after the first entry.
      tx_q = '{16'($urandom), 16'($urandom)};
      clear_mon();
      bus.sample_ready = 1'b0;
      pulse_start(10'd2);
      c = 0;
      while (bus.sample_valid !== 1'b1 && c < 1000) begin @(negedge clk); c++; end
      check("C_first_valid", 32'(bus.sample_valid), 32'd1);
      repeat (8) @(negedge clk);
      stalling = 1'b1;
      snap = rises;
      repeat (92) @(negedge clk);
      stalling = 1'b0;
      check("C_stall_rises", 32'(rises), 32'(snap));
      check("C_stall_pins", 32'(stall_bad), 32'd0);
      check("C_hold_stable", 32'(hold_bad), 32'd0);
      check("C_still_valid", 32'(bus.sample_valid), 32'd1);
      @(posedge clk); #1 bus.sample_ready = 1'b1;
      wait_done(1000);
      check_txn(2);

      // Rejected counts, then starts while busy.
      reject_case(10'd0);
      reject_case(10'(MAX_WORDS + 1));
      tx_q = '{16'($urandom), 16'($urandom)};
      clear_mon();
      pulse_start(10'd2);
      repeat (30) @(negedge clk);
      pulse_start(10'd5);
      repeat (100) @(negedge clk);
      pulse_start(10'd1);
      wait_done(1000);
      check_txn(2);

      // Last entry outlives done; it blocks new requests until consumed.
      tx_q = '{16'($urandom)};
      clear_mon();
      bus.sample_ready = 1'b0;
      pulse_start(10'd1);
      wait_done(1000);
      check("D_valid_after_done", 32'(bus.sample_valid), 32'd1);
      check("D_pending_entry", 32'({bus.sample_axis, bus.sample_data}), 32'(tx_q[0]));
      pulse_start(10'd1);
      check("D_blocked_busy", 32'(bus.busy), 32'd0);
      check("D_blocked_cs", 32'(bus.cs_n), 32'd1);
      repeat (5) @(negedge clk);
      check("D_blocked_done", 32'(done_cnt), 32'd1);
      @(posedge clk); #1 bus.sample_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("D_valid_cleared", 32'(bus.sample_valid), 32'd0);
      check("D_n_samples", 32'(got_q.size()), 32'd1);

      // Reset at bit 5 of an entry, then a fresh transaction.
      tx_q = '{16'($urandom), 16'($urandom)};
      clear_mon();
      pulse_start(10'd2);
      c = 0;
      while (rises < 13 && c < 2000) begin @(negedge clk); c++; end
      check("E_abort_point", 32'(rises), 32'd13);
      rst = 1'b0;
      #1;
      check("E_cs_n", 32'(bus.cs_n), 32'd1);
      check("E_sclk", 32'(bus.sclk), 32'd0);
      check("E_valid", 32'(bus.sample_valid), 32'd0);
      check("E_busy", 32'(bus.busy), 32'd0);
      repeat (3) @(negedge clk);
      check("E_no_done", 32'(done_cnt), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tx_q = '{16'($urandom)};
      clear_mon();
      pulse_start(10'd1);
      wait_done(1000);
      check_txn(1);

      // Randomized transactions with a throttled consumer.
      for (int t = 0; t < 4; t++) begin
         n = $urandom_range(1, 4);
         tx_q.delete();
         for (int i = 0; i < n; i++) tx_q.push_back(16'($urandom));
         clear_mon();
         pulse_start(10'(n));
         rand_ready = 1'b1;
         wait_done(400 + 300 * n);
         wait_samples(n, 300);
         @(negedge clk);
         rand_ready = 1'b0;
         @(posedge clk); #2;
         bus.sample_ready = 1'b1;
         repeat (2) @(negedge clk);
         check_txn(n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adxl362_fifo_reader.md
ADXL362_FIFO_READER -- requirements
Module: adxl362_fifo_reader

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles (legal range 2..255).
REQ-002 Parameter MAX_WORDS, default 512: largest legal num_words.
REQ-003 clk  input  1  single clock; all state advances on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low; block held in reset while rst==0.
REQ-005 start  input  1  one-cycle request to drain num_words FIFO entries.
REQ-006 num_words  input  10  entry count, sampled when start is accepted.
REQ-007 busy  output  1  high from accepted start until done.
REQ-008 done  output  1  one-cycle pulse at transaction end.
REQ-009 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 cs_n  output  1  SPI chip select, active-low.
REQ-011 mosi  output  1  SPI data to the device, MSB first.
REQ-012 miso  input  1  SPI data from the device, MSB first.
REQ-013 sample_data  output  14  FIFO entry bits [13:0] (sign-extended 12-bit sample).
REQ-014 sample_axis  output  2  FIFO entry bits [15:14] (00 X, 01 Y, 10 Z, 11 temp).
REQ-015 sample_valid  output  1  sample_data/sample_axis hold an unconsumed entry.
REQ-016 sample_ready  input  1  consumer accepts an entry when sample_valid & sample_ready at posedge clk.

Function
REQ-017 FSM states: IDLE, SETUP, CMD, WORD, STALL, HOLD, FINISH.
REQ-018 IDLE: start with 1<=num_words<=MAX_WORDS -> SETUP, cs_n low and busy high on the next cycle.
REQ-019 start with num_words==0 or >MAX_WORDS: no SPI activity, done pulses once on the next cycle, busy stays low.
REQ-020 start while busy is ignored.
REQ-021 SETUP: cs_n low, sclk low for CLK_DIV cycles, then -> CMD.
REQ-022 Each bit: sclk low CLK_DIV cycles, then high CLK_DIV cycles; mosi changes only while sclk low; miso sampled on the clk where sclk rises.
REQ-023 CMD: shifts 8'h0D on mosi, MSB first, then -> WORD; mosi driven 0 outside CMD.
REQ-024 WORD: 16 bits per entry, low byte first then high byte, each byte MSB first; entry = {high byte, low byte}.
REQ-025 On the cycle after the 16th miso sample, entry loads into the output register and sample_valid rises.
REQ-026 sample_valid stays high, and data/axis stay stable, until accepted.
REQ-027 Before the first bit of a following entry, if sample_valid & !sample_ready: -> STALL, sclk held low, cs_n held low, until acceptance, then resume.
REQ-028 After the last entry: HOLD keeps sclk low CLK_DIV cycles, then cs_n rises, done pulses, busy falls in the same cycle, -> FINISH -> IDLE next cycle.
REQ-029 The last entry's sample_valid is independent of done; it remains until accepted, and a new start is accepted only when sample_valid is low.
REQ-030 Internal word counter 10 bits, decrements per loaded entry; transaction ends when counter reaches 0.
REQ-031 Total rising sclk edges per transaction = 8 + 16*num_words.

Reset
REQ-032 rst low asynchronously forces: cs_n=1, sclk=0, mosi=0, busy=0, done=0, sample_valid=0, sample_data=0, sample_axis=0, FSM=IDLE, counters=0.
REQ-033 Reset mid-transaction aborts with no done pulse; the partial entry is discarded.

Verification
REQ-034 Reset: hold rst=0 with clk stopped -> all outputs at REQ-032 values immediately.
REQ-035 num_words=1, miso model returns 0x34 then 0x81 -> mosi carries 0x0D, 24 sclk rises, sample_axis=2'b10, sample_data=14'h0134, then done.
REQ-036 num_words=3, sample_ready=1, entries 0x0001/0x4002/0x8003 -> three samples in order with axis 00/01/10, 56 sclk rises, one done.
REQ-037 num_words=2, sample_ready=0 for 100 cycles after first sample_valid -> sclk flat low, cs_n low during stall; the second entry completes after release.
REQ-038 start with num_words=0 -> done 1-cycle pulse, cs_n never low; start pulsed while busy -> no effect on rise count.
REQ-039 rst pulled low at bit 5 of an entry -> cs_n=1, sample_valid=0 immediately, no done; fresh start afterwards is a normal transaction.
